// File: rtl/dial_pkg.sv
// Shared constants, types and small arithmetic helpers for the spinner dial encoder.
package dial_pkg;

    localparam int FRAC_BITS  = 4;
    localparam int SLOW_STEP  = 15;
    localparam int FAST_STEP  = 25;
    localparam int ANALOG_SHL = 4;
    localparam int ACCEL_HOLD = 8;

    localparam int ACC_W = 8 + FRAC_BITS;

    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_STRB  = 2'd1,
        EV_SPIN  = 2'd2,
        EV_MOUSE = 2'd3
    } dial_event_e;

    // Sign-extend an 8-bit delta to accumulator width and scale into fractional units.
    function automatic acc_t scale_delta(input logic [7:0] delta);
        acc_t ext;
        ext = {{(ACC_W-8){delta[7]}}, delta};
        return ext << ANALOG_SHL;
    endfunction

    function automatic acc_t step_of(input logic fast_sel);
        return fast_sel ? acc_t'(FAST_STEP) : acc_t'(SLOW_STEP);
    endfunction

endpackage

// File: rtl/dial_edge_det.sv
// Primed edge detector: TOGGLE=1 flags any change, TOGGLE=0 flags a 0->1 rise.
// The first clock after reset only captures the input, so no edge is seen out of reset.
module dial_edge_det #(
    parameter bit TOGGLE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic evt
);

    logic prev_r;
    logic primed_r;
    logic evt_r;
    logic hit_s;

    // Raw edge condition against the previous sample.
    always_comb begin
        hit_s = 1'b0;
        if (TOGGLE) begin
            hit_s = din ^ prev_r;
        end else begin
            hit_s = din & ~prev_r;
        end
    end

    // Sample history, priming flag and registered event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r   <= 1'b0;
            primed_r <= 1'b0;
            evt_r    <= 1'b0;
        end else begin
            prev_r   <= din;
            primed_r <= 1'b1;
            evt_r    <= primed_r & hit_s;
        end
    end

    assign evt = evt_r;

endmodule

// File: rtl/dial_encoder.sv
// Rotary dial position accumulator fed by digital buttons, spinner and mouse deltas.
// Build option DIAL_ACCEL_EN: holding one direction for ACCEL_HOLD strobes forces the fast step.
module dial_encoder
    import dial_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       minus,
    input  logic       plus,
    input  logic       fast,
    input  logic       strobe,
    input  logic [8:0] spin_in,
    input  logic [8:0] mouse_in,
    output logic [7:0] spin_out,
    output logic       spin_upd,
    output logic       src_mouse
);

    logic       e_strb_s;
    logic       e_spin_s;
    logic       e_mouse_s;
    logic [7:0] spin_d_r;
    logic [7:0] mouse_d_r;
    acc_t       acc_r;
    logic       src_mouse_r;
    logic       spin_upd_r;
    acc_t       a_s;
    acc_t       d_s;
    acc_t       step_s;
    acc_t       acc_next_s;
    logic       src_next_s;
    logic       fast_sel_s;

    dial_edge_det #(.TOGGLE(1'b0)) u_strb (
        .clk(clk), .reset_n(reset_n), .din(strobe), .evt(e_strb_s)
    );
    dial_edge_det #(.TOGGLE(1'b1)) u_spin (
        .clk(clk), .reset_n(reset_n), .din(spin_in[8]), .evt(e_spin_s)
    );
    dial_edge_det #(.TOGGLE(1'b1)) u_mouse (
        .clk(clk), .reset_n(reset_n), .din(mouse_in[8]), .evt(e_mouse_s)
    );

`ifdef DIAL_ACCEL_EN
    localparam int HOLD_W = $clog2(ACCEL_HOLD + 1);
    logic [HOLD_W-1:0] hold_r;

    // Saturating count of strobes seen while exactly one direction is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if (!(plus ^ minus)) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if (e_strb_s && (hold_r != HOLD_W'(ACCEL_HOLD))) begin
            hold_r <= hold_r + HOLD_W'(1);
        end else begin
            hold_r <= hold_r;
        end
    end

    assign fast_sel_s = fast | (hold_r == HOLD_W'(ACCEL_HOLD));
`else
    assign fast_sel_s = fast;
`endif

    // Source select, analog/digital terms and next accumulator value.
    always_comb begin
        a_s        = acc_t'(0);
        d_s        = acc_t'(0);
        step_s     = step_of(fast_sel_s);
        src_next_s = src_mouse_r;
        // Spin wins a same-cycle collision; the mouse delta is then discarded.
        if (e_spin_s) begin
            src_next_s = 1'b0;
            a_s        = scale_delta(spin_d_r);
        end else if (e_mouse_s) begin
            src_next_s = 1'b1;
            a_s        = scale_delta(mouse_d_r);
        end else begin
            src_next_s = src_mouse_r;
        end
        if (e_strb_s && plus && !minus) begin
            d_s = step_s;
        end else if (e_strb_s && minus && !plus) begin
            d_s = acc_t'(0) - step_s;
        end else begin
            d_s = acc_t'(0);
        end
        acc_next_s = acc_r + a_s + d_s;
    end

    // Delta capture aligned with the registered events, plus accumulator state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spin_d_r    <= 8'h00;
            mouse_d_r   <= 8'h00;
            acc_r       <= acc_t'(0);
            src_mouse_r <= 1'b0;
            spin_upd_r  <= 1'b0;
        end else begin
            spin_d_r    <= spin_in[7:0];
            mouse_d_r   <= mouse_in[7:0];
            acc_r       <= acc_next_s;
            src_mouse_r <= src_next_s;
            spin_upd_r  <= (acc_next_s[ACC_W-1:FRAC_BITS] != acc_r[ACC_W-1:FRAC_BITS]);
        end
    end

    assign spin_out  = acc_r[ACC_W-1:FRAC_BITS];
    assign spin_upd  = spin_upd_r;
    assign src_mouse = src_mouse_r;

endmodule

// File: tb/tb_dial_encoder.sv
// Scoreboard bench for dial_encoder: stimulus pushes expected updates, a monitor checks each spin_upd pulse.
module tb_dial_encoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       minus = 1'b0;
    logic       plus = 1'b0;
    logic       fast = 1'b0;
    logic       strobe = 1'b0;
    logic [8:0] spin_in = 9'h000;
    logic [8:0] mouse_in = 9'h000;
    logic [7:0] spin_out;
    logic       spin_upd;
    logic       src_mouse;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int m_acc = 0;
    bit m_src = 1'b0;
    int m_hold = 0;
    logic [8:0] exp_q[$];

    dial_encoder dut (
        .clk(clk), .reset_n(reset_n), .minus(minus), .plus(plus), .fast(fast),
        .strobe(strobe), .spin_in(spin_in), .mouse_in(mouse_in),
        .spin_out(spin_out), .spin_upd(spin_upd), .src_mouse(src_mouse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every update pulse must match the oldest expected update.
    always @(negedge clk) begin
        if (reset_n && spin_upd) begin
            logic [8:0] e;
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: got spin_out %0h with no update expected", spin_out);
            end else begin
                e = exp_q.pop_front();
                check("upd_out", int'(spin_out), int'(e[8:1]));
                check("upd_src", int'(src_mouse), int'(e[0]));
            end
        end
    end

    task automatic set_buttons(input bit p, input bit m, input bit f);
        @(negedge clk);
        plus = p; minus = m; fast = f;
        if (!(p ^ m)) m_hold = 0;
    endtask

    // Issue one combination of events and queue the expected update, if any.
    task automatic apply(input bit st, input bit sp, input logic [7:0] sd,
                         input bit mo, input logic [7:0] md);
        int a, d, step, old_int;
        bit fsel;
        @(negedge clk);
        if (st) strobe = 1'b1;
        if (sp) spin_in = {~spin_in[8], sd};
        if (mo) mouse_in = {~mouse_in[8], md};
        a = 0; d = 0;
        if (sp) a = int'($signed(sd)) * 16;
        else if (mo) a = int'($signed(md)) * 16;
        if (sp) m_src = 1'b0;
        else if (mo) m_src = 1'b1;
        if (st) begin
            fsel = fast;
`ifdef DIAL_ACCEL_EN
            if (plus ^ minus) begin
                if (m_hold >= 8) fsel = 1'b1;
                if (m_hold < 8) m_hold++;
            end
`endif
            step = fsel ? 25 : 15;
            if (plus && !minus) d = step;
            else if (minus && !plus) d = -step;
        end
        old_int = m_acc / 16;
        m_acc = (m_acc + a + d + 8192) % 4096;
        if ((m_acc / 16) != old_int) exp_q.push_back({8'(m_acc / 16), m_src});
        @(negedge clk);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drained(input string name);
        repeat (4) @(negedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Reset with edges already pending on every input to exercise priming.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_out", int'(spin_out), 0);
        check("rst_upd", int'(spin_upd), 0);
        check("rst_src", int'(src_mouse), 0);
        exp_q.delete();
        m_acc = 0; m_src = 1'b0; m_hold = 0; pulses = 0;
        plus = 1'b0; minus = 1'b0; fast = 1'b0;
        strobe = 1'b1; spin_in = 9'h17F; mouse_in = 9'h140;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        check("prime_out", int'(spin_out), 0);
        check("prime_src", int'(src_mouse), 0);
        check("prime_pulses", pulses, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        do_reset();

        // Slow digital steps: first strobe is fractional only.
        set_buttons(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        drained("frac_drain");
        check("frac_no_upd", pulses, 0);
        repeat (15) apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        set_buttons(1'b0, 1'b0, 1'b0);
        drained("slow_drain");
        check("slow_out", int'(spin_out), 8'h0F);

        // Fast minus from zero wraps downward.
        do_reset();
        set_buttons(1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        set_buttons(1'b0, 1'b0, 1'b0);
        drained("fastm_drain");
        check("fastm_out", int'(spin_out), 8'hFE);
        check("fastm_pulses", pulses, 1);

        // Spinner deltas.
        do_reset();
        apply(1'b0, 1'b1, 8'h05, 1'b0, 8'h00);
        check("spin1_out", int'(spin_out), 8'h05);
        apply(1'b0, 1'b1, 8'hFB, 1'b0, 8'h00);
        drained("spin_drain");
        check("spin2_out", int'(spin_out), 8'h00);
        check("spin_pulses", pulses, 2);
        check("spin_src", int'(src_mouse), 0);

        // Mouse takes over, then spinner takes back.
        do_reset();
        apply(1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
        check("mouse_out", int'(spin_out), 8'h10);
        check("mouse_src", int'(src_mouse), 1);
        apply(1'b0, 1'b1, 8'h03, 1'b0, 8'h00);
        drained("mouse_drain");
        check("back_out", int'(spin_out), 8'h13);
        check("back_src", int'(src_mouse), 0);

        // Simultaneous strobe and spinner contributions are summed.
        do_reset();
        set_buttons(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 8'h02, 1'b0, 8'h00);
        check("sum1_out", int'(spin_out), 8'h02);
        apply(1'b1, 1'b1, 8'h02, 1'b0, 8'h00);
        set_buttons(1'b0, 1'b0, 1'b0);
        drained("sum_drain");
        check("sum2_out", int'(spin_out), 8'h05);

        // Analog wrap in both directions.
        do_reset();
        apply(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
        check("wrapdn_out", int'(spin_out), 8'hFF);
        apply(1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
        drained("wrap_drain");
        check("wrapup_out", int'(spin_out), 8'h00);
        check("wrap_pulses", pulses, 2);

        // Same-cycle spin and mouse: spin wins; both buttons cancel.
        do_reset();
        apply(1'b0, 1'b1, 8'h02, 1'b1, 8'h40);
        check("both_out", int'(spin_out), 8'h02);
        check("both_src", int'(src_mouse), 0);
        set_buttons(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        set_buttons(1'b0, 1'b0, 1'b0);
        drained("cancel_drain");
        check("cancel_out", int'(spin_out), 8'h02);

        // Ten held strobes: acceleration kicks in after eight when enabled.
        do_reset();
        set_buttons(1'b1, 1'b0, 1'b0);
        repeat (10) apply(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        set_buttons(1'b0, 1'b0, 1'b0);
        drained("hold_drain");
`ifdef DIAL_ACCEL_EN
        check("hold_out", int'(spin_out), 8'h0A);
`else
        check("hold_out", int'(spin_out), 8'h09);
`endif

        // Reset mid-operation clears state immediately.
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
